// File: rtl/grf_wb_if.sv
// Bus bundle between the two writeback requesters, the GRF write port and the
// decode-stage hazard query for grf_wb_arbiter.
interface grf_wb_if #(
  parameter int CNT_W = 16
);
  logic             a_valid;
  logic             a_ready;
  logic [4:0]       a_addr;
  logic [31:0]      a_data;
  logic [31:0]      a_pc;
  logic             b_valid;
  logic             b_ready;
  logic [4:0]       b_addr;
  logic [31:0]      b_data;
  logic [31:0]      b_pc;
  logic             grf_we;
  logic [4:0]       grf_a3;
  logic [31:0]      grf_wd;
  logic [31:0]      grf_pc;
  logic [4:0]       rd_addr1;
  logic [4:0]       rd_addr2;
  logic             hazard1;
  logic             hazard2;
  logic [CNT_W-1:0] conflict_cnt;

  modport slave (
    input  a_valid, a_addr, a_data, a_pc,
    input  b_valid, b_addr, b_data, b_pc,
    input  rd_addr1, rd_addr2,
    output a_ready, b_ready,
    output grf_we, grf_a3, grf_wd, grf_pc,
    output hazard1, hazard2, conflict_cnt
  );

  modport master (
    output a_valid, a_addr, a_data, a_pc,
    output b_valid, b_addr, b_data, b_pc,
    output rd_addr1, rd_addr2,
    input  a_ready, b_ready,
    input  grf_we, grf_a3, grf_wd, grf_pc,
    input  hazard1, hazard2, conflict_cnt
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter sharing the single GRF write port between the ALU/load
// writeback (A) and MDU completion (B), with RAW hazard flags for decode.
module grf_wb_arbiter #(
  parameter int CNT_W   = 16,
  parameter int START_B = 0
) (
  input  logic     CLK,
  input  logic     RESET,
  grf_wb_if.slave  bus
);

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_t;

  localparam ptr_t PTR_RESET = (START_B != 0) ? PTR_B : PTR_A;

  ptr_t             ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             we_reg, we_next;
  logic [4:0]       a3_reg;
  logic [31:0]      wd_reg, pc_reg;
  logic             grant_a, grant_b;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data, sel_pc;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_reg <= PTR_RESET;
      cnt_reg <= '0;
      we_reg  <= 1'b0;
      a3_reg  <= 5'd0;
      wd_reg  <= 32'd0;
      pc_reg  <= 32'd0;
    end else begin
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
      we_reg  <= we_next;
      // $0 writes are swallowed: the visible A3/WD/PC keep the last real write.
      if (we_next) begin
        a3_reg <= sel_addr;
        wd_reg <= sel_data;
        pc_reg <= sel_pc;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    sel_addr = bus.a_addr;
    sel_data = bus.a_data;
    sel_pc   = bus.a_pc;
    if (bus.a_valid && bus.b_valid) begin
      grant_a  = (ptr_reg == PTR_A);
      grant_b  = ~grant_a;
      ptr_next = grant_a ? PTR_B : PTR_A;
      if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + CNT_W'(1);
    end else begin
      grant_a = bus.a_valid;
      grant_b = bus.b_valid;
    end
    if (grant_b) begin
      sel_addr = bus.b_addr;
      sel_data = bus.b_data;
      sel_pc   = bus.b_pc;
    end
    we_next = (grant_a || grant_b) && (sel_addr != 5'd0);
  end

  // Reset overrides everything, so nothing may be reported as accepted then.
  assign bus.a_ready      = grant_a & ~RESET;
  assign bus.b_ready      = grant_b & ~RESET;
  assign bus.grf_we       = we_reg;
  assign bus.grf_a3       = a3_reg;
  assign bus.grf_wd       = wd_reg;
  assign bus.grf_pc       = pc_reg;
  assign bus.conflict_cnt = cnt_reg;

  logic [4:0] rd_addr_arr [2];
  logic [1:0] hazard_vec;

  assign rd_addr_arr[0] = bus.rd_addr1;
  assign rd_addr_arr[1] = bus.rd_addr2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hazard
      assign hazard_vec[gi] = (rd_addr_arr[gi] != 5'd0) &&
                              ((we_reg      && (a3_reg     == rd_addr_arr[gi])) ||
                               (bus.a_valid && (bus.a_addr == rd_addr_arr[gi])) ||
                               (bus.b_valid && (bus.b_addr == rd_addr_arr[gi])));
    end
  endgenerate

  assign bus.hazard1 = hazard_vec[0];
  assign bus.hazard2 = hazard_vec[1];

endmodule
